// File: rtl/adaptive_filter_decimator_if.sv
// Sample and result streams of the adaptive filter decimator.
// The decimator connects through the master modport, its environment through the slave modport.
interface adaptive_filter_decimator_if #(
  parameter int WORDLENGTH = 14
);
  logic [WORDLENGTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic [WORDLENGTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;

  modport master (
    input  s_tdata,
    input  s_tvalid,
    input  m_tready,
    output m_tdata,
    output m_tvalid
  );

  modport slave (
    output s_tdata,
    output s_tvalid,
    output m_tready,
    input  m_tdata,
    input  m_tvalid
  );
endinterface

// File: rtl/adaptive_filter_decimator.sv
// Averages groups of 2^DECIM_LOG2 valid samples with round-half-up and offers each
// average on a valid/ready output; results arriving against backpressure are counted.
module adaptive_filter_decimator #(
  parameter int WORDLENGTH        = 14,
  parameter int FRACTIONAL_LENGTH = 6,
  parameter int DECIM_LOG2        = 3,
  parameter int DROP_CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        flush,
  adaptive_filter_decimator_if.master bus,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);
  localparam int ACC_W = WORDLENGTH + DECIM_LOG2;
  localparam int HALF  = 1 << (DECIM_LOG2 - 1);

  logic signed [ACC_W-1:0]  r_acc;
  logic [DECIM_LOG2-1:0]    r_phase;
  logic [WORDLENGTH-1:0]    r_tdata;
  logic                     r_tvalid;
  logic [DROP_CNT_W-1:0]    r_drop_cnt;

  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic [WORDLENGTH-1:0]    w_result;
  logic                     w_capture;
  logic                     w_last;
  logic                     w_new;

  // The Q format is identical on both sides, so the fraction width needs no handling.
  always_comb begin
    w_capture = bus.s_tvalid && !flush;
    w_last    = (r_phase == '1);
    w_new     = w_capture && w_last;
    w_sum     = r_acc + ACC_W'($signed(bus.s_tdata));
    w_rnd     = w_sum + ACC_W'(HALF);
    // The averaged value always fits the sample width, so truncation is lossless.
    w_result  = WORDLENGTH'(w_rnd >>> DECIM_LOG2);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_acc      <= '0;
      r_phase    <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (flush) begin
        r_acc   <= '0;
        r_phase <= '0;
      end else if (bus.s_tvalid) begin
        if (w_last) begin
          r_acc   <= '0;
          r_phase <= '0;
        end else begin
          r_acc   <= w_sum;
          r_phase <= r_phase + 1'b1;
        end
      end

      if (w_new) begin
        if (!r_tvalid || bus.m_tready) begin
          r_tdata  <= w_result;
          r_tvalid <= 1'b1;
        end else if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end else if (r_tvalid && bus.m_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign bus.m_tdata  = r_tdata;
  assign bus.m_tvalid = r_tvalid;
  assign drop_cnt     = r_drop_cnt;
endmodule
